// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage in front of the program-memory ROM.
//
// Holds the program counter, presents it as the ROM byte address, selects the
// next PC (branch > jump > stall > sequential) and captures the ROM's
// combinational output into the IF/ID pipeline register.
//
// Parameters:
//   DATA_WIDTH  width of PC, addresses and instruction words
//   RESET_ADDR  PC value after reset (word-aligned)
//   NOP_WORD    instruction word placed in IF/ID on flush or redirect
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   Stall             hold PC and IF/ID
//   Flush             bubble IF/ID on the next edge
//   BranchTaken       redirect from EX (highest priority)
//   BranchTarget      branch target byte address
//   JumpTaken         redirect from ID
//   JumpTarget        jump target byte address
//   Instruction       combinational ROM word for the current PC
//   PC                current PC / ROM byte address
//   IFID_Instruction  registered instruction for decode
//   IFID_PCPlus4      registered PC+4 of that instruction
//   IFID_Valid        1 = IFID_Instruction is a real fetched instruction
//   MisalignFault     sticky misaligned-redirect flag (only with MISALIGN_TRAP_EN)
//
// Build option: define MISALIGN_TRAP_EN to align redirect targets to a word
// boundary and flag misaligned targets on MisalignFault.

module fetch_unit #(
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]    RESET_ADDR = '0,
    parameter logic [DATA_WIDTH-1:0]    NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic                  JumpTaken,
    input  logic [DATA_WIDTH-1:0] JumpTarget,
    input  logic [DATA_WIDTH-1:0] Instruction,
`ifdef MISALIGN_TRAP_EN
    output logic                  MisalignFault,
`endif
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid
);

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] target_raw;
    logic [DATA_WIDTH-1:0] target;

    // Wraps modulo 2^DATA_WIDTH with no flag.
    assign pc_plus4   = PC + DATA_WIDTH'(4);
    assign redirect   = BranchTaken | JumpTaken;
    // Branch belongs to the older instruction, so it wins over jump.
    assign target_raw = BranchTaken ? BranchTarget : JumpTarget;

`ifdef MISALIGN_TRAP_EN
    logic misaligned;

    assign misaligned = redirect && (target_raw[1:0] != 2'b00);
    assign target     = {target_raw[DATA_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MisalignFault <= 1'b0;
        end else if (misaligned) begin
            MisalignFault <= 1'b1;
        end
    end
`else
    assign target = target_raw;
`endif

    // Program counter: a redirect overrides Stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC <= RESET_ADDR;
        end else if (redirect) begin
            PC <= target;
        end else if (!Stall) begin
            PC <= pc_plus4;
        end
    end

    // IF/ID register: a redirect squashes the wrong-path fetch like a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IFID_Instruction <= NOP_WORD;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
        end else if (redirect || Flush) begin
            IFID_Instruction <= NOP_WORD;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
        end else if (!Stall) begin
            IFID_Instruction <= Instruction;
            IFID_PCPlus4     <= pc_plus4;
            IFID_Valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// Directed steps followed by a randomized run. The reference state is a set
// of plain variables updated once per cycle from the fetch-stage rules.

module tb_fetch_unit;

    localparam int unsigned DW  = 32;
    localparam logic [31:0] RA  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic          clk;
    logic          reset;
    logic          Stall;
    logic          Flush;
    logic          BranchTaken;
    logic [31:0]   BranchTarget;
    logic          JumpTaken;
    logic [31:0]   JumpTarget;
    logic [31:0]   Instruction;
    logic [31:0]   PC;
    logic [31:0]   IFID_Instruction;
    logic [31:0]   IFID_PCPlus4;
    logic          IFID_Valid;
`ifdef MISALIGN_TRAP_EN
    logic          MisalignFault;
`endif

    fetch_unit #(
        .DATA_WIDTH (DW),
        .RESET_ADDR (RA),
        .NOP_WORD   (NOP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .Flush            (Flush),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .JumpTaken        (JumpTaken),
        .JumpTarget       (JumpTarget),
        .Instruction      (Instruction),
`ifdef MISALIGN_TRAP_EN
        .MisalignFault    (MisalignFault),
`endif
        .PC               (PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [31:0] m_pc, m_ins, m_p4;
    logic        m_v, m_fault;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".PC"},    PC,               m_pc);
        chk({tag, ".INS"},   IFID_Instruction, m_ins);
        chk({tag, ".P4"},    IFID_PCPlus4,     m_p4);
        chk({tag, ".VALID"}, {31'b0, IFID_Valid}, {31'b0, m_v});
`ifdef MISALIGN_TRAP_EN
        chk({tag, ".FAULT"}, {31'b0, MisalignFault}, {31'b0, m_fault});
`endif
    endtask

    task automatic model_reset();
        m_pc = RA; m_ins = NOP; m_p4 = '0; m_v = 1'b0; m_fault = 1'b0;
    endtask

    // Advance one clock with the currently driven inputs, then check.
    task automatic step(input string tag);
        logic [31:0] seq, npc, tgt;
        logic [31:0] n_ins, n_p4;
        logic        n_v, n_fault;
        seq     = m_pc + 32'd4;
        n_fault = m_fault;
        if (BranchTaken)    tgt = BranchTarget;
        else                tgt = JumpTarget;
        if (BranchTaken || JumpTaken) begin
`ifdef MISALIGN_TRAP_EN
            if (tgt % 4 != 0) n_fault = 1'b1;
            tgt = tgt - (tgt % 4);
`endif
            npc = tgt;
        end else if (Stall) begin
            npc = m_pc;
        end else begin
            npc = seq;
        end
        if (BranchTaken || JumpTaken || Flush) begin
            n_ins = NOP; n_p4 = '0; n_v = 1'b0;
        end else if (Stall) begin
            n_ins = m_ins; n_p4 = m_p4; n_v = m_v;
        end else begin
            n_ins = Instruction; n_p4 = seq; n_v = 1'b1;
        end
        @(posedge clk);
        #1;
        m_pc = npc; m_ins = n_ins; m_p4 = n_p4; m_v = n_v; m_fault = n_fault;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        Stall = 0; Flush = 0; BranchTaken = 0; JumpTaken = 0;
        BranchTarget = '0; JumpTarget = '0;
    endtask

    initial begin
        idle_inputs();
        Instruction = 32'h2008_0005;
        reset = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Free-running sequential fetch: PC 4, 8
        step("seq1");
        step("seq2");

        // Stall two cycles at PC=8, then release
        Stall = 1;
        step("stall1");
        step("stall2");
        Stall = 0;
        step("unstall");

        // Branch + jump + stall together: branch wins
        BranchTaken = 1; BranchTarget = 32'h40;
        JumpTaken = 1;   JumpTarget   = 32'h80;
        Stall = 1;
        step("br_prio");
        idle_inputs();
        Instruction = 32'h1234_5678;
        step("after_br");

        // Jump alone, then flush alone
        JumpTaken = 1; JumpTarget = 32'h10;
        step("jump");
        idle_inputs();
        step("at16");
        Flush = 1;
        step("flush");
        Flush = 0;
        step("after_flush");

        // Flush with stall: flush wins on IF/ID, PC holds
        Flush = 1; Stall = 1;
        step("flush_stall");
        idle_inputs();

        // Wrap from the top of the address space
        JumpTaken = 1; JumpTarget = 32'hFFFF_FFFC;
        step("jump_top");
        idle_inputs();
        step("wrap");
        step("post_wrap");

        // Misaligned redirect target
        BranchTaken = 1; BranchTarget = 32'h0000_0102;
        step("misalign");
        idle_inputs();
        step("post_misalign");

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            BranchTaken  = ($urandom_range(0, 7) == 0);
            JumpTaken    = ($urandom_range(0, 7) == 0);
            Stall        = ($urandom_range(0, 3) == 0);
            Flush        = ($urandom_range(0, 7) == 0);
            BranchTarget = $urandom;
            JumpTarget   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                BranchTarget[1:0] = 2'b00;
                JumpTarget[1:0]   = 2'b00;
            end
            Instruction  = $urandom;
            step("rand");
        end

        // Asynchronous reset mid-cycle during a redirect
        idle_inputs();
        step("pre_areset");
        BranchTaken = 1; BranchTarget = 32'h100;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("areset");
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        Instruction = 32'hCAFE_F00D;
        step("rel1");
        step("rel2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the program memory ROM. It holds the program counter, drives the ROM's byte address, and selects the next PC from sequential, branch or jump sources. It captures the ROM's combinational instruction output into an IF/ID pipeline register, with stall and flush control for the decode stage.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instruction words
RESET_ADDR, 32'h0000_0000, PC value loaded on reset; must be word-aligned
NOP_WORD, 32'h0000_0000, instruction word written into IF/ID on flush or bubble

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
Stall  input  1  hold PC and IF/ID contents (hazard unit)
Flush  input  1  replace IF/ID contents with a bubble on the next edge
BranchTaken  input  1  redirect from the resolved branch in EX
BranchTarget  input  DATA_WIDTH  branch target byte address
JumpTaken  input  1  redirect from the jump decoded in ID
JumpTarget  input  DATA_WIDTH  jump target byte address
Instruction  input  DATA_WIDTH  combinational word returned by the program memory
PC  output  DATA_WIDTH  current PC; byte address to the program memory
IFID_Instruction  output  DATA_WIDTH  registered instruction for decode
IFID_PCPlus4  output  DATA_WIDTH  registered PC+4 of that instruction
IFID_Valid  output  1  1 = IFID_Instruction is a real fetched instruction

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-redirect): PC=RESET_ADDR, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0. Release takes effect at the first rising clk edge after reset=1.
- Internal signal PCPlus4 = PC + 4, modulo 2^DATA_WIDTH. 32'hFFFF_FFFC wraps to 0 with no flag.
- Next-PC priority, evaluated each rising edge:
  1. BranchTaken=1: PC <= BranchTarget.
  2. else JumpTaken=1: PC <= JumpTarget.
  3. else Stall=1: PC holds.
  4. else: PC <= PCPlus4.
- Branch has priority over jump because it belongs to the older instruction. A redirect overrides Stall.
- IF/ID register update, in priority order:
  - BranchTaken, JumpTaken or Flush: load NOP_WORD, PCPlus4=0, Valid=0. The wrong-path fetch is squashed.
  - else Stall: hold all three fields.
  - else: IFID_Instruction <= Instruction, IFID_PCPlus4 <= PCPlus4, IFID_Valid <= 1.
- Latency: one cycle from PC presentation to IFID_Instruction. A redirect costs one bubble at ID.
- Targets are used exactly as given; the low two bits are ignored by memory addressing.
- No combinational path from any input to PC or the IFID_* outputs. All outputs are registered.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- When defined: extra output MisalignFault, 1 bit, reset 0.
  - If the selected redirect target has bits [1:0] != 0, PC loads the target with bits [1:0] forced to 0.
  - MisalignFault is set to 1 on that same edge and stays sticky until reset.
  - IF/ID is flushed as for any redirect.
- When undefined: no port. Targets are loaded unmodified.

Test Plan:
- Reset release, Instruction tied to 32'h2008_0005, 4 cycles with no control -> PC = 0, 4, 8, 12; IFID_Valid=0 in cycle 0, then 1 with IFID_PCPlus4 = 4, 8, 12.
- At PC=8, Stall=1 for 2 cycles -> PC stays 8 and IF/ID holds its contents. Release -> PC=12 on the next edge.
- BranchTaken=1, BranchTarget=32'h40 together with Stall=1 and JumpTaken=1 (JumpTarget=32'h80) -> PC=32'h40; IF/ID = NOP_WORD, Valid=0. Next cycle fetches from 0x40, Valid=1.
- Flush=1 alone at PC=16 -> PC=20, IFID_Valid=0 and IFID_Instruction=0 for one cycle.
- JumpTaken to 32'hFFFF_FFFC, then 2 free cycles -> PC=32'hFFFF_FFFC, then wraps to 0.
- Assert reset mid-cycle while BranchTaken=1 -> PC=RESET_ADDR and IFID_Valid=0 immediately, without waiting for a clock edge.
